// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall and branch flush control.
// Optional event counters are enabled by defining HAZARD_UNIT_PERF_CNT_EN.
module hazard_unit (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [4:0] i_rs1_d,
    input  logic [4:0] i_rs2_d,
    input  logic [4:0] i_rs1_e,
    input  logic [4:0] i_rs2_e,
    input  logic [4:0] i_rd_e,
    input  logic [4:0] i_rd_m,
    input  logic [4:0] i_rd_wb,
    input  logic       i_res_src_b0_e,
    input  logic [1:0] i_pc_src_e,
    output logic [1:0] o_fw_a_e,
    output logic [1:0] o_fw_b_e,
    output logic       o_fw_a_d,
    output logic       o_fw_b_d,
    output logic       o_pc_stall,
    output logic       o_if_id_stall,
    output logic       o_if_id_flush,
    output logic       o_id_ex_flush
`ifdef HAZARD_UNIT_PERF_CNT_EN
    ,
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_flush_cnt
`endif
);

    logic lw_stall;
    logic br_taken;

    assign lw_stall = i_res_src_b0_e && (i_rd_e != 5'd0) &&
                      ((i_rs1_d == i_rd_e) || (i_rs2_d == i_rd_e));
    assign br_taken = (i_pc_src_e != 2'b00);

    always_comb begin
        o_fw_a_e      = 2'b00;
        o_fw_b_e      = 2'b00;
        o_fw_a_d      = 1'b0;
        o_fw_b_d      = 1'b0;
        o_pc_stall    = 1'b0;
        o_if_id_stall = 1'b0;
        o_if_id_flush = 1'b1;
        o_id_ex_flush = 1'b1;
        if (!i_rst) begin
            // Memory stage holds the younger result, so it is checked first.
            if ((i_rs1_e == i_rd_m) && (i_rd_m != 5'd0)) begin
                o_fw_a_e = 2'b10;
            end else if ((i_rs1_e == i_rd_wb) && (i_rd_wb != 5'd0)) begin
                o_fw_a_e = 2'b01;
            end
            if ((i_rs2_e == i_rd_m) && (i_rd_m != 5'd0)) begin
                o_fw_b_e = 2'b10;
            end else if ((i_rs2_e == i_rd_wb) && (i_rd_wb != 5'd0)) begin
                o_fw_b_e = 2'b01;
            end
            o_fw_a_d      = (i_rs1_d == i_rd_wb) && (i_rd_wb != 5'd0);
            o_fw_b_d      = (i_rs2_d == i_rd_wb) && (i_rd_wb != 5'd0);
            o_pc_stall    = lw_stall;
            o_if_id_stall = lw_stall;
            o_if_id_flush = br_taken;
            o_id_ex_flush = lw_stall || br_taken;
        end
    end

`ifdef HAZARD_UNIT_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        // Counters saturate rather than wrap.
        if (lw_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (br_taken && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`else
    logic unused_clk;
    assign unused_clk = i_clk;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit; counter checks are built only
// when HAZARD_UNIT_PERF_CNT_EN is defined.
module tb_hazard_unit;

    logic       clk;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_wb;
    logic       res_src_b0_e;
    logic [1:0] pc_src_e;
    logic [1:0] fw_a_e, fw_b_e;
    logic       fw_a_d, fw_b_d;
    logic       pc_stall, if_id_stall, if_id_flush, id_ex_flush;
    logic [3:0] ctrl;
`ifdef HAZARD_UNIT_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    hazard_unit dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_rs1_d        (rs1_d),
        .i_rs2_d        (rs2_d),
        .i_rs1_e        (rs1_e),
        .i_rs2_e        (rs2_e),
        .i_rd_e         (rd_e),
        .i_rd_m         (rd_m),
        .i_rd_wb        (rd_wb),
        .i_res_src_b0_e (res_src_b0_e),
        .i_pc_src_e     (pc_src_e),
        .o_fw_a_e       (fw_a_e),
        .o_fw_b_e       (fw_b_e),
        .o_fw_a_d       (fw_a_d),
        .o_fw_b_d       (fw_b_d),
        .o_pc_stall     (pc_stall),
        .o_if_id_stall  (if_id_stall),
        .o_if_id_flush  (if_id_flush),
        .o_id_ex_flush  (id_ex_flush)
`ifdef HAZARD_UNIT_PERF_CNT_EN
        ,
        .o_stall_cnt    (stall_cnt),
        .o_flush_cnt    (flush_cnt)
`endif
    );

    // {pc_stall, if_id_stall, if_id_flush, id_ex_flush}
    assign ctrl = {pc_stall, if_id_stall, if_id_flush, id_ex_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        rs1_d = 5'd0; rs2_d = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0;
        rd_e = 5'd0; rd_m = 5'd0; rd_wb = 5'd0;
        res_src_b0_e = 1'b0; pc_src_e = 2'b00;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        rs1_e = 5'd5; rd_m = 5'd5; rs1_d = 5'd4; rd_wb = 5'd4;
        rd_e = 5'd4; res_src_b0_e = 1'b1;
        #1;
        n_vec++;
        if (fw_a_e !== 2'b00) begin
            n_err++; $display("FAIL reset_fw_a_e got %b want 00", fw_a_e);
        end
        n_vec++;
        if (fw_a_d !== 1'b0) begin
            n_err++; $display("FAIL reset_fw_a_d got %b want 0", fw_a_d);
        end
        n_vec++;
        if (ctrl !== 4'b0011) begin
            n_err++; $display("FAIL reset_ctrl got %b want 0011", ctrl);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (fw_a_e !== 2'b10) begin
            n_err++; $display("FAIL release_fw_a_e got %b want 10", fw_a_e);
        end
        n_vec++;
        if ({fw_a_d, ctrl} !== 5'b1_1101) begin
            n_err++; $display("FAIL release_d_ctrl got %b want 11101", {fw_a_d, ctrl});
        end
    endtask

    task automatic test_fwd_exec();
        clear_inputs();
        rs1_e = 5'd5; rd_m = 5'd5; rd_wb = 5'd0;
        #1;
        n_vec++;
        if (fw_a_e !== 2'b10) begin
            n_err++; $display("FAIL fwa_mem got %b want 10", fw_a_e);
        end
        rs1_e = 5'd0;
        #1;
        n_vec++;
        if (fw_a_e !== 2'b00) begin
            n_err++; $display("FAIL fwa_x0 got %b want 00", fw_a_e);
        end
        rd_m = 5'd0;
        #1;
        n_vec++;
        if (fw_a_e !== 2'b00) begin
            n_err++; $display("FAIL fwa_x0_all got %b want 00", fw_a_e);
        end
        clear_inputs();
        rs2_e = 5'd5; rd_m = 5'd5; rd_wb = 5'd5; rd_e = 5'd5; rs1_e = 5'd7;
        #1;
        n_vec++;
        if (fw_b_e !== 2'b10) begin
            n_err++; $display("FAIL fwb_prio got %b want 10", fw_b_e);
        end
        n_vec++;
        if (fw_a_e !== 2'b00) begin
            n_err++; $display("FAIL fwa_nomatch got %b want 00", fw_a_e);
        end
        rd_m = 5'd3;
        #1;
        n_vec++;
        if (fw_b_e !== 2'b01) begin
            n_err++; $display("FAIL fwb_wb got %b want 01", fw_b_e);
        end
        rs1_e = 5'd3;
        #1;
        n_vec++;
        if ({fw_a_e, fw_b_e} !== 4'b1001) begin
            n_err++; $display("FAIL fw_both got %b want 1001", {fw_a_e, fw_b_e});
        end
        rs1_e = 5'd0; rd_wb = 5'd0; rs2_e = 5'd0;
        #1;
        n_vec++;
        if (fw_b_e !== 2'b00) begin
            n_err++; $display("FAIL fwb_x0_wb got %b want 00", fw_b_e);
        end
    endtask

    task automatic test_fwd_decode();
        clear_inputs();
        rs1_d = 5'd5; rs2_d = 5'd5; rd_wb = 5'd5;
        #1;
        n_vec++;
        if ({fw_a_d, fw_b_d} !== 2'b11) begin
            n_err++; $display("FAIL fwd_match got %b want 11", {fw_a_d, fw_b_d});
        end
        rs2_d = 5'd6;
        #1;
        n_vec++;
        if ({fw_a_d, fw_b_d} !== 2'b10) begin
            n_err++; $display("FAIL fwd_partial got %b want 10", {fw_a_d, fw_b_d});
        end
        rs1_d = 5'd0; rs2_d = 5'd0; rd_wb = 5'd0;
        #1;
        n_vec++;
        if ({fw_a_d, fw_b_d} !== 2'b00) begin
            n_err++; $display("FAIL fwd_x0 got %b want 00", {fw_a_d, fw_b_d});
        end
    endtask

    task automatic test_load_use();
        clear_inputs();
        rs1_d = 5'd2; rd_e = 5'd2; res_src_b0_e = 1'b0;
        #1;
        n_vec++;
        if (ctrl !== 4'b0000) begin
            n_err++; $display("FAIL lu_noload got %b want 0000", ctrl);
        end
        res_src_b0_e = 1'b1;
        #1;
        n_vec++;
        if (ctrl !== 4'b1101) begin
            n_err++; $display("FAIL lu_rs1 got %b want 1101", ctrl);
        end
        rs1_d = 5'd9; rs2_d = 5'd2;
        #1;
        n_vec++;
        if (ctrl !== 4'b1101) begin
            n_err++; $display("FAIL lu_rs2 got %b want 1101", ctrl);
        end
        rs2_d = 5'd0; rd_e = 5'd0;
        #1;
        n_vec++;
        if (ctrl !== 4'b0000) begin
            n_err++; $display("FAIL lu_x0 got %b want 0000", ctrl);
        end
    endtask

    task automatic test_branch();
        clear_inputs();
        pc_src_e = 2'b01;
        #1;
        n_vec++;
        if (ctrl !== 4'b0011) begin
            n_err++; $display("FAIL br_01 got %b want 0011", ctrl);
        end
        pc_src_e = 2'b10;
        #1;
        n_vec++;
        if (ctrl !== 4'b0011) begin
            n_err++; $display("FAIL br_10 got %b want 0011", ctrl);
        end
        pc_src_e = 2'b01; rs1_d = 5'd2; rd_e = 5'd2; res_src_b0_e = 1'b1;
        #1;
        n_vec++;
        if (ctrl !== 4'b1111) begin
            n_err++; $display("FAIL br_and_lu got %b want 1111", ctrl);
        end
    endtask

`ifdef HAZARD_UNIT_PERF_CNT_EN
    task automatic test_counters();
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({stall_cnt, flush_cnt} !== 64'd0) begin
            n_err++; $display("FAIL cnt_reset got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
        rst = 1'b0;
        rs1_d = 5'd2; rd_e = 5'd2; res_src_b0_e = 1'b1;
        repeat (3) @(negedge clk);
        clear_inputs();
        pc_src_e = 2'b11;
        repeat (2) @(negedge clk);
        clear_inputs();
        @(negedge clk);
        n_vec++;
        if (stall_cnt !== 32'd3) begin
            n_err++; $display("FAIL stall_cnt got %0d want 3", stall_cnt);
        end
        n_vec++;
        if (flush_cnt !== 32'd2) begin
            n_err++; $display("FAIL flush_cnt got %0d want 2", flush_cnt);
        end
        rst = 1'b1;
        rs1_d = 5'd2; rd_e = 5'd2; res_src_b0_e = 1'b1; pc_src_e = 2'b01;
        @(negedge clk);
        n_vec++;
        if ({stall_cnt, flush_cnt} !== 64'd0) begin
            n_err++; $display("FAIL cnt_clear got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({stall_cnt, flush_cnt} !== {32'd1, 32'd1}) begin
            n_err++; $display("FAIL cnt_resume got %0d/%0d want 1/1", stall_cnt, flush_cnt);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_fwd_exec();
        test_fwd_decode();
        test_load_use();
        test_branch();
`ifdef HAZARD_UNIT_PERF_CNT_EN
        test_counters();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
